frame_window_buffer: RTL and testbench

//  Frame-aware sliding-window line buffer; generalises the fixed 3x3 FIFO-chain buffer.

---
 rtl/frame_window_buffer_pkg.sv | 22 ++
 rtl/frame_window_buffer_if.sv | 43 ++++
 rtl/frame_window_buffer_line_ram.sv | 29 ++
 rtl/frame_window_buffer.sv | 183 ++++++++++++++++++
 tb/tb_frame_window_buffer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_window_buffer_pkg.sv
// Shared definitions for the frame-aware sliding-window line buffer.
// Holds the FSM state encodings, the per-window tag carried alongside the
// output data, and the helper that maps a window element (row, col) to its
// element slot in the flattened window bus.
package frame_window_buffer_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FILL   = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;

   typedef struct packed {
      logic eol;
      logic eof;
   } win_tag_t;

   // Element (r, c) sits at slot r*win_w + c; r=0 is the newest row and
   // c=0 the newest (rightmost) pixel.
   function automatic int win_idx(input int r, input int c, input int win_w);
      return (r * win_w) + c;
   endfunction

endpackage

// File: rtl/frame_window_buffer_if.sv
// Pixel-in / window-out bus of the frame window buffer.
//   img_width, img_height : frame geometry, taken on the accepted SOF pixel
//   p_valid, p_sof, pixel : pixel stream from the source, p_ready back
//   win_valid, win_eol, win_eof, window : window stream, win_ready back
//   frame_err             : one-cycle error pulse
// master = source/sink side, slave = the buffer itself.
interface frame_window_buffer_if #(
   parameter int PIXEL_WIDTH    = 8,
   parameter int CHANNELS       = 1,
   parameter int MAX_LINE_WIDTH = 1024,
   parameter int MAX_LINES      = 1024,
   parameter int WIN_W          = 3,
   parameter int WIN_H          = 3
);
   localparam int CW   = PIXEL_WIDTH * CHANNELS;
   localparam int WW   = $clog2(MAX_LINE_WIDTH + 1);
   localparam int HW   = $clog2(MAX_LINES + 1);
   localparam int WINB = WIN_W * WIN_H * CW;

   logic [WW-1:0]   img_width;
   logic [HW-1:0]   img_height;
   logic            p_valid;
   logic            p_sof;
   logic [CW-1:0]   pixel;
   logic            p_ready;
   logic            win_ready;
   logic            win_valid;
   logic            win_eol;
   logic            win_eof;
   logic [WINB-1:0] window;
   logic            frame_err;

   modport master (
      output img_width, img_height, p_valid, p_sof, pixel, win_ready,
      input  p_ready, win_valid, win_eol, win_eof, window, frame_err
   );

   modport slave (
      input  img_width, img_height, p_valid, p_sof, pixel, win_ready,
      output p_ready, win_valid, win_eol, win_eof, window, frame_err
   );

endinterface

// File: rtl/frame_window_buffer_line_ram.sv
// One line of pixel history: DEPTH words of WIDTH bits, combinational read,
// write on the rising clock edge. Contents are never reset.
//   clk   : clock
//   we    : write enable
//   addr  : shared read/write address (pixel column)
//   wdata : word written at addr
//   rdata : word currently stored at addr (pre-write value)
module line_ram #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/frame_window_buffer.sv
// Frame-aware sliding-window line buffer. Accepts a raster pixel stream,
// keeps WIN_H-1 lines of history and emits every WIN_W x WIN_H window that
// lies fully inside the image, tagged with end-of-row / end-of-frame.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : frame_window_buffer_if.slave (pixel in, window out, frame_err)
//
// state  | meaning
// IDLE   | waiting for an SOF pixel; non-SOF pixels are consumed and dropped
// FILL   | rows 0..WIN_H-2 being written into line memory, no windows yet
// STREAM | rows WIN_H-1..H-1, windows emitted once col >= WIN_W-1
module frame_window_buffer
   import frame_window_buffer_pkg::*;
#(
   parameter int PIXEL_WIDTH    = 8,
   parameter int CHANNELS       = 1,
   parameter int MAX_LINE_WIDTH = 1024,
   parameter int MAX_LINES      = 1024,
   parameter int WIN_W          = 3,
   parameter int WIN_H          = 3
) (
   input logic                  clk,
   input logic                  rst,
   frame_window_buffer_if.slave bus
);

   localparam int CW   = PIXEL_WIDTH * CHANNELS;
   localparam int WW   = $clog2(MAX_LINE_WIDTH + 1);
   localparam int HW   = $clog2(MAX_LINES + 1);
   localparam int AW   = $clog2(MAX_LINE_WIDTH);
   localparam int WINB = WIN_W * WIN_H * CW;

   localparam logic [WW-1:0] W_MIN       = WW'(WIN_W);
   localparam logic [WW-1:0] W_MAX       = WW'(MAX_LINE_WIDTH);
   localparam logic [WW-1:0] COL_WIN_MIN = WW'(WIN_W - 1);
   localparam logic [HW-1:0] H_MIN       = HW'(WIN_H);
   localparam logic [HW-1:0] H_MAX       = HW'(MAX_LINES);
   localparam logic [HW-1:0] ROW_WIN_MIN = HW'(WIN_H - 1);
   localparam logic [HW-1:0] ROW_FILL_LAST = HW'(WIN_H - 2);

   logic [1:0]      state;
   logic [WW-1:0]   col, w_q, w_eff, c_cur;
   logic [HW-1:0]   row, h_q, h_eff, r_cur;
   logic            p_ready, accept, sof_acc, cfg_bad, pix_en;
   logic            last_col, last_row, emit;
   logic [CW-1:0]   rd   [WIN_H-1];
   logic [CW-1:0]   colv [WIN_H];
   logic [WINB-1:0] sr_q, sr_d, window_q;
   logic            win_valid_q, frame_err_q;
   win_tag_t        tag_q;

   // Dropped pixels in IDLE never touch the output register, so they are
   // always taken; everything else needs the output register to be free.
   assign p_ready = ((state == ST_IDLE) & ~bus.p_sof) | ~win_valid_q | bus.win_ready;
   assign accept  = bus.p_valid & p_ready;
   assign sof_acc = accept & bus.p_sof;

   assign cfg_bad = (bus.img_width  < W_MIN) | (bus.img_width  > W_MAX) |
                    (bus.img_height < H_MIN) | (bus.img_height > H_MAX);

   // An SOF pixel is frame pixel (0,0) of the new geometry, whatever state
   // the current frame was in.
   assign pix_en = sof_acc ? ~cfg_bad : (accept & (state != ST_IDLE));
   assign w_eff  = sof_acc ? bus.img_width  : w_q;
   assign h_eff  = sof_acc ? bus.img_height : h_q;
   assign c_cur  = sof_acc ? '0 : col;
   assign r_cur  = sof_acc ? '0 : row;

   assign last_col = (c_cur == (w_eff - WW'(1)));
   assign last_row = (r_cur == (h_eff - HW'(1)));
   assign emit     = pix_en & (r_cur >= ROW_WIN_MIN) & (c_cur >= COL_WIN_MIN);

   // Column vector: newest row first, then line memories oldest-last.
   // Line k is rewritten with the word it passed down, so the history
   // shifts one line per row at the same column.
   assign colv[0] = bus.pixel;

   for (genvar k = 1; k < WIN_H; k++) begin : g_colv
      assign colv[k] = rd[k-1];
   end

   for (genvar k = 0; k < WIN_H - 1; k++) begin : g_line
      line_ram #(
         .DEPTH (MAX_LINE_WIDTH),
         .WIDTH (CW)
      ) u_line_ram (
         .clk   (clk),
         .we    (pix_en),
         .addr  (c_cur[AW-1:0]),
         .wdata (colv[k]),
         .rdata (rd[k])
      );
   end

   // Shift the window one column; older columns are cleared at the start of
   // each row so nothing from the previous row lingers in the register.
   always_comb begin
      sr_d = sr_q;
      for (int r = 0; r < WIN_H; r++) begin
         for (int c = 0; c < WIN_W; c++) begin
            if (c == 0) begin
               sr_d[win_idx(r, 0, WIN_W)*CW +: CW] = colv[r];
            end else if (c_cur == '0) begin
               sr_d[win_idx(r, c, WIN_W)*CW +: CW] = '0;
            end else begin
               sr_d[win_idx(r, c, WIN_W)*CW +: CW] = sr_q[win_idx(r, c-1, WIN_W)*CW +: CW];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         col         <= '0;
         row         <= '0;
         w_q         <= '0;
         h_q         <= '0;
         sr_q        <= '0;
         window_q    <= '0;
         win_valid_q <= 1'b0;
         tag_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= sof_acc & (cfg_bad | (state != ST_IDLE));

         if (sof_acc) begin
            w_q <= bus.img_width;
            h_q <= bus.img_height;
            if (cfg_bad) begin
               state <= ST_IDLE;
            end else begin
               state <= ST_FILL;
               col   <= WW'(1);
               row   <= '0;
            end
         end else if (pix_en) begin
            if (last_col) begin
               col <= '0;
               row <= r_cur + HW'(1);
            end else begin
               col <= c_cur + WW'(1);
            end
            case (state)
               ST_FILL: begin
                  if (last_col && (r_cur == ROW_FILL_LAST)) begin
                     state <= ST_STREAM;
                  end
               end
               ST_STREAM: begin
                  if (last_col && last_row) begin
                     state <= ST_IDLE;
                     row   <= '0;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end

         if (pix_en) begin
            sr_q <= sr_d;
         end

         if (emit) begin
            win_valid_q <= 1'b1;
            window_q    <= sr_d;
            tag_q.eol   <= last_col;
            tag_q.eof   <= last_col & last_row;
         end else if (bus.win_ready) begin
            win_valid_q <= 1'b0;
            tag_q       <= '0;
         end
      end
   end

   assign bus.p_ready   = p_ready;
   assign bus.win_valid = win_valid_q;
   assign bus.win_eol   = tag_q.eol;
   assign bus.win_eof   = tag_q.eof;
   assign bus.window    = window_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_frame_window_buffer.sv
// Self-checking bench for frame_window_buffer (3x3 window, 8-bit pixels).
// A reference model built on a plain image array predicts each window at
// the moment its pixel is accepted and queues it; a monitor pops and
// compares every window handshake independently of the stimulus.
module tb_frame_window_buffer;

   typedef struct {
      logic [71:0] win;
      logic        eol;
      logic        eof;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   frame_window_buffer_if bus ();

   frame_window_buffer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_chk = 0;
   int          n_fail = 0;
   int          n_win = 0;
   int          n_err = 0;
   logic [71:0] first_win = '0;
   exp_t        sb[$];
   int          wr_mode = 0;
   logic        wr_fixed = 1'b1;
   logic        frame_px = 1'b0;

   logic [7:0]  img [16][16];
   bit          in_frame = 0;
   int          mr = 0, mc = 0, mw = 0, mh = 0;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: frame position, geometry check and window extraction
   // straight from the image rules.
   task automatic model_accept(input logic [7:0] pix, input bit sof);
      exp_t e;
      int   w, h;
      if (sof) begin
         w = int'(bus.img_width);
         h = int'(bus.img_height);
         if (w < 3 || w > 1024 || h < 3 || h > 1024) begin
            in_frame = 0;
            return;
         end
         in_frame = 1;
         mw = w;
         mh = h;
         mr = 0;
         mc = 0;
      end else if (!in_frame) begin
         return;
      end
      img[mr][mc] = pix;
      if (mr >= 2 && mc >= 2) begin
         e.win = '0;
         for (int wr = 0; wr < 3; wr++)
            for (int wc = 0; wc < 3; wc++)
               e.win[(wr*3+wc)*8 +: 8] = img[mr-wr][mc-wc];
         e.eol = (mc == mw - 1);
         e.eof = (mc == mw - 1) && (mr == mh - 1);
         sb.push_back(e);
      end
      if (mc == mw - 1) begin
         mc = 0;
         mr++;
         if (mr == mh) in_frame = 0;
      end else begin
         mc++;
      end
   endtask

   // Called at a falling edge; returns at a falling edge.
   task automatic send(input logic [7:0] pix, input bit sof, input int gap);
      bit got = 0;
      bus.pixel   = pix;
      bus.p_sof   = sof;
      bus.p_valid = 1'b1;
      frame_px    = sof | in_frame;
      for (int t = 0; t < 200 && !got; t++) begin
         #4;
         got = bus.p_ready;
         if (got) model_accept(pix, sof);
         @(negedge clk);
      end
      bus.p_valid = 1'b0;
      bus.p_sof   = 1'b0;
      if (!got) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: p_ready stayed 0, required 1 within 200 cycles");
      end
      repeat ($urandom_range(0, gap)) @(negedge clk);
   endtask

   // Raster frame; stops before pixel (stop_r, stop_c) if it is reached.
   task automatic frame(input int w, input int h, input bit pat,
                        input int stop_r, input int stop_c, input int gap);
      bus.img_width  = 11'(w);
      bus.img_height = 11'(h);
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            if (r == stop_r && c == stop_c) return;
            send(pat ? 8'(r*16 + c) : 8'($urandom), (r == 0) && (c == 0), gap);
         end
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((sb.size() != 0 || bus.win_valid) && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: %0d windows still expected, required 0", sb.size());
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      bus.win_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (wr_mode)
            0:       bus.win_ready = wr_fixed;
            1:       bus.win_ready = ~bus.win_ready;
            default: bus.win_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: samples just before each rising edge.
   initial begin
      logic        hold_pend;
      logic [71:0] hold_win;
      logic [1:0]  hold_tag;
      exp_t        e;
      hold_pend = 1'b0;
      hold_win  = '0;
      hold_tag  = '0;
      forever begin
         @(negedge clk);
         #4;
         if (rst) begin
            hold_pend = 1'b0;
            continue;
         end
         if (hold_pend) begin
            chk("hold_valid", 72'(bus.win_valid), 72'd1);
            chk("hold_window", bus.window, hold_win);
            chk("hold_flags", 72'({bus.win_eol, bus.win_eof}), 72'(hold_tag));
            hold_pend = 1'b0;
         end
         if (bus.frame_err) n_err++;
         if (bus.win_valid && !bus.win_ready) begin
            hold_pend = 1'b1;
            hold_win  = bus.window;
            hold_tag  = {bus.win_eol, bus.win_eof};
            if (bus.p_valid && frame_px) chk("p_ready_stall", 72'(bus.p_ready), 72'd0);
         end
         if (bus.win_valid && bus.win_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_window: got %0h, required no window", bus.window);
            end else begin
               e = sb.pop_front();
               chk("window", bus.window, e.win);
               chk("win_eol", 72'(bus.win_eol), 72'(e.eol));
               chk("win_eof", 72'(bus.win_eof), 72'(e.eof));
            end
            if (n_win == 0) first_win = bus.window;
            n_win++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before the end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.img_width  = '0;
      bus.img_height = '0;
      bus.p_valid    = 1'b0;
      bus.p_sof      = 1'b0;
      bus.pixel      = '0;
      repeat (3) @(negedge clk);
      chk("rst_win_valid", 72'(bus.win_valid), 72'd0);
      chk("rst_flags", 72'({bus.win_eol, bus.win_eof, bus.frame_err}), 72'd0);
      chk("rst_window", bus.window, 72'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1: plain frame, downstream always ready
      n_win = 0; n_err = 0;
      frame(8, 4, 1, -1, -1, 0);
      drain();
      chk("t1_count", 72'(n_win), 72'd12);
      chk("t1_first_row0", 72'(first_win[23:0]), 72'h202122);
      chk("t1_err", 72'(n_err), 72'd0);

      // 2: same frame, win_ready alternating every cycle
      wr_mode = 1;
      n_win = 0;
      frame(8, 4, 1, -1, -1, 0);
      drain();
      chk("t2_count", 72'(n_win), 72'd12);

      // 3: back-to-back frames, random data and random backpressure
      wr_mode = 2;
      n_win = 0;
      frame(8, 4, 0, -1, -1, 2);
      frame(5, 3, 0, -1, -1, 2);
      drain();
      chk("t3_count", 72'(n_win), 72'd15);
      chk("t3_err", 72'(n_err), 72'd0);

      // 4: SOF at row 2, col 3 aborts and restarts the frame
      n_win = 0; n_err = 0;
      frame(8, 4, 1, 2, 3, 1);
      frame(8, 4, 0, -1, -1, 1);
      drain();
      chk("t4_count", 72'(n_win), 72'd13);
      chk("t4_err", 72'(n_err), 72'd1);

      // 5: illegal geometry; every pixel consumed, no windows
      wr_mode = 0; wr_fixed = 1'b1;
      n_win = 0; n_err = 0;
      frame(2, 4, 0, -1, -1, 0);
      frame(5, 2, 0, -1, -1, 0);
      drain();
      chk("t5_count", 72'(n_win), 72'd0);
      chk("t5_err", 72'(n_err), 72'd2);

      // 6: reset while a window is stalled in row 3
      n_win = 0; n_err = 0;
      frame(8, 4, 0, 3, 5, 0);
      drain();
      wr_fixed = 1'b0;
      @(negedge clk);
      send(8'($urandom), 1'b0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_valid", 72'(bus.win_valid), 72'd0);
      chk("t6_rst_flags", 72'({bus.win_eol, bus.win_eof, bus.frame_err}), 72'd0);
      chk("t6_rst_window", bus.window, 72'd0);
      rst = 1'b0;
      sb.delete();
      in_frame = 0;
      wr_fixed = 1'b1;
      @(negedge clk);
      send(8'h5a, 1'b0, 0);
      send(8'ha5, 1'b0, 0);
      n_win = 0;
      frame(8, 4, 0, -1, -1, 1);
      drain();
      chk("t6_count", 72'(n_win), 72'd12);
      chk("t6_err", 72'(n_err), 72'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
